mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers in the E stage.
- Consumes MDOp and HILOSel from the E-stage decoder plus forwarded E-stage operands.
- Raises Start/Busy so the hazard unit stalls D-stage md instructions.
- Supplies the mfhi/mflo read value to the E/M pipeline register.

---
 rtl/mult_div_unit_pkg.sv | 42 ++++
 rtl/mult_div_unit.sv | 92 +++++++++
 tb/tb_mult_div_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MDOp / HILOSel encodings and the divide helper for the E-stage multiply/divide unit.
// Pure definitions only: no clocking, no latency, no flow control.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_MADD  = 3'b111
  } md_op_e;

  localparam logic SEL_HI = 1'b0;
  localparam logic SEL_LO = 1'b1;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

  function automatic logic is_start_op(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD};
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  // Sign-magnitude signed divide returning {rem, quo}; caller guarantees b != 0.
  // Working on magnitudes makes 0x80000000 / -1 wrap to 0x80000000 instead of trapping.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31])         r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO; result computed at Start, committed after N busy cycles.
// Start is combinational in IDLE; md ops arriving while Busy are ignored (hazard unit stalls them).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic        HILOSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HILO_out
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [63:0] pend_q, pend_d;
  logic [63:0] sprod, result;

  assign sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  always_comb begin
    result = {hi_q, lo_q};
    case (md_op_e'(MDOp))
      MD_MULT:  result = sprod;
      MD_MULTU: result = {32'b0, A} * {32'b0, B};
      MD_DIV:   if (B != 32'b0) result = sdiv(A, B);
      MD_DIVU:  if (B != 32'b0) result = {A % B, A / B};
      MD_MADD:  result = {hi_q, lo_q} + sprod;
      default:  result = {hi_q, lo_q};
    endcase
  end

  assign Start    = is_start_op(MDOp) && (state_q == ST_IDLE);
  assign Busy     = (state_q == ST_BUSY);
  assign HILO_out = (HILOSel == SEL_LO) ? lo_q : hi_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pend_d  = result;
          cnt_d   = is_div_op(MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = ST_BUSY;
        end else if (MDOp == MD_MTHI) begin
          hi_d = A;
        end else if (MDOp == MD_MTLO) begin
          lo_d = A;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a 64-bit arithmetic reference of HI/LO.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  MDOp;
  logic        HILOSel;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] HILO_out;

  int checks = 0;
  int failures = 0;
  int busy_op_viol = 0;
  bit allow_busy_op = 0;
  logic [31:0] hi_m = 0, lo_m = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .HILOSel(HILOSel),
    .A(A), .B(B), .Start(Start), .Busy(Busy), .HILO_out(HILO_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Hazard-unit contract: no md op is presented while the unit is busy.
  always @(negedge clk) begin
    #2;
    if (reset && !allow_busy_op && Busy === 1'b1 && MDOp !== 3'b000) busy_op_viol++;
  end

  // Architectural reference: new {HI,LO} after an op, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                         input logic [31:0] hi, lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'b001: return sa * sb;
      3'b010: return ua * ub;
      3'b011: begin
        if (b == 0) return {hi, lo};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'b100: begin
        if (b == 0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'b101: return {a, lo};
      3'b110: return {hi, a};
      3'b111: return {hi, lo} + longint'(sa * sb);
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int model_cycles(input logic [2:0] op);
    if (op == 3'b011 || op == 3'b100) return 10;
    return 5;
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    HILOSel = 1'b0; #1; h = HILO_out;
    HILOSel = 1'b1; #1; l = HILO_out;
  endtask

  // Presents one md op for a single cycle, then counts Busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                        output logic st, output int nbusy);
    @(negedge clk);
    MDOp = op; A = a; B = b;
    #1 st = Start;
    @(negedge clk);
    MDOp = 3'b000;
    nbusy = 0;
    while (Busy === 1'b1 && nbusy < 64) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 0; MDOp = 0; A = 0; B = 0; HILOSel = 0;
    repeat (3) @(negedge clk);
    read_hilo(h, l);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", Start); end
    checks++; if (h !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", h); end
    checks++; if (l !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", l); end
    reset = 1;
    @(negedge clk);
    hi_m = 0; lo_m = 0;
  endtask

  // Directed table first, then random ops (with corner operands mixed in).
  task automatic test_arith(input int n_random);
    logic [2:0]  ops[$];
    logic [31:0] as[$], bs[$];
    logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    logic [63:0] exp;
    logic [31:0] h, l;
    logic st;
    int nb;
    ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111, 3'b100, 3'b011, 3'b011, 3'b100};
    as  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h0, 32'h5, 32'h3, 32'h7,
            32'h80000000, 32'h7, 32'hFFFFFFFF};
    bs  = '{32'h2, 32'h2, 32'h2, 32'h0, 32'h0, 32'h4, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hA};
    for (int i = 0; i < n_random; i++) begin
      ops.push_back(3'($urandom_range(1, 7)));
      as.push_back(($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom);
      bs.push_back(($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom);
    end
    for (int i = 0; i < ops.size(); i++) begin
      exp = model(ops[i], as[i], bs[i], hi_m, lo_m);
      if (ops[i] == 3'b101 || ops[i] == 3'b110) begin
        @(negedge clk);
        MDOp = ops[i]; A = as[i]; B = bs[i];
        #1;
        checks++; if (Start !== 1'b0) begin failures++; $display("FAIL mt_start op=%0d got=%b exp=0", ops[i], Start); end
        @(negedge clk);
        MDOp = 3'b000;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mt_busy op=%0d got=%b exp=0", ops[i], Busy); end
      end else begin
        run_op(ops[i], as[i], bs[i], st, nb);
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL start op=%0d got=%b exp=1", ops[i], st); end
        checks++; if (nb != model_cycles(ops[i])) begin failures++; $display("FAIL busy_len op=%0d got=%0d exp=%0d", ops[i], nb, model_cycles(ops[i])); end
      end
      hi_m = exp[63:32]; lo_m = exp[31:0];
      read_hilo(h, l);
      checks++; if (h !== hi_m) begin failures++; $display("FAIL hi op=%0d a=%h b=%h got=%h exp=%h", ops[i], as[i], bs[i], h, hi_m); end
      checks++; if (l !== lo_m) begin failures++; $display("FAIL lo op=%0d a=%h b=%h got=%h exp=%h", ops[i], as[i], bs[i], l, lo_m); end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] h, l;
    logic [63:0] exp;
    logic st;
    int nb;
    @(negedge clk); MDOp = 3'b101; A = 32'hDEAD0001;
    @(negedge clk); MDOp = 3'b110; A = 32'hBEEF0002;
    @(negedge clk); MDOp = 3'b001; A = 32'h00012345; B = 32'h00000100;
    @(negedge clk); MDOp = 3'b000;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    read_hilo(h, l);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    checks++; if (h !== 32'h0) begin failures++; $display("FAIL abort_hi got=%h exp=0", h); end
    checks++; if (l !== 32'h0) begin failures++; $display("FAIL abort_lo got=%h exp=0", l); end
    @(negedge clk); reset = 1;
    hi_m = 0; lo_m = 0;
    repeat (8) @(negedge clk);
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h0) begin failures++; $display("FAIL abort_no_commit got=%h exp=0", {h, l}); end
    exp = model(3'b001, 32'hFFFF0003, 32'h7, hi_m, lo_m);
    run_op(3'b001, 32'hFFFF0003, 32'h7, st, nb);
    hi_m = exp[63:32]; lo_m = exp[31:0];
    read_hilo(h, l);
    checks++; if (nb != 5) begin failures++; $display("FAIL post_abort_busy got=%0d exp=5", nb); end
    checks++; if ({h, l} !== {hi_m, lo_m}) begin failures++; $display("FAIL post_abort_mult got=%h exp=%h", {h, l}, {hi_m, lo_m}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l;
    logic [63:0] first, second;
    logic [10:0] pattern;
    logic st_busy, st_idle;
    int nb;
    logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom;
    allow_busy_op = 1;
    first  = model(3'b001, a1, b1, hi_m, lo_m);
    second = model(3'b001, a2, b2, first[63:32], first[31:0]);
    @(negedge clk);
    MDOp = 3'b001; A = a1; B = b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin A = a2; B = b2; end
      #1;
      pattern[11-k] = Busy;
      if (k == 1) st_busy = Start;
      if (k == 6) begin st_idle = Start; read_hilo(h, l); end
    end
    MDOp = 3'b000;
    checks++; if (pattern !== 11'b11111_0_11111) begin failures++; $display("FAIL b2b_pattern got=%b exp=11111011111", pattern); end
    checks++; if (st_busy !== 1'b0) begin failures++; $display("FAIL b2b_start_busy got=%b exp=0", st_busy); end
    checks++; if (st_idle !== 1'b1) begin failures++; $display("FAIL b2b_start_idle got=%b exp=1", st_idle); end
    checks++; if ({h, l} !== first) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {h, l}, first); end
    nb = 0;
    while (Busy === 1'b1 && nb < 64) begin nb++; @(negedge clk); end
    allow_busy_op = 0;
    hi_m = second[63:32]; lo_m = second[31:0];
    read_hilo(h, l);
    checks++; if ({h, l} !== second) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {h, l}, second); end
  endtask

  task automatic test_busy_guard();
    checks++;
    if (busy_op_viol !== 0) begin failures++; $display("FAIL busy_op_guard got=%0d exp=0", busy_op_viol); end
  endtask

  initial begin
    test_reset();
    test_arith(40);
    test_reset_abort();
    test_back_to_back();
    test_arith(10);
    test_busy_guard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
